// File: rtl/redutor_if.sv
// ----------------------------------------------------------------------------
// redutor_if
//   Handshake bundle for the redutor narrowing unit.
//
//   Parameters
//     tamIn   input word width
//     tamOut  output beat width
//
//   Signals (direction seen from the redutor, i.e. the slave modport)
//     in             in   tamIn   input word
//     inValid        in   1       input word present
//     inReady        out  1       unit accepts a word this cycle
//     extSide        in   1       0: keep low side, 1: keep high side
//     twoComplement  in   1       1: signed overflow check
//     split          in   1       1: emit both halves as two beats
//     out            out  tamOut  result beat
//     outValid       out  1       out is valid
//     outReady       in   1       consumer takes the beat
//     overflow       out  1       information lost in the current beat
//
//   The master modport is the producer/consumer side (datapath or bench).
// ----------------------------------------------------------------------------
interface redutor_if #(
    parameter int tamIn  = 32,
    parameter int tamOut = 16
);
    logic [tamIn-1:0]  in;
    logic              inValid;
    logic              inReady;
    logic              extSide;
    logic              twoComplement;
    logic              split;
    logic [tamOut-1:0] out;
    logic              outValid;
    logic              outReady;
    logic              overflow;

    modport master (
        output in, inValid, extSide, twoComplement, split, outReady,
        input  inReady, out, outValid, overflow
    );

    modport slave (
        input  in, inValid, extSide, twoComplement, split, outReady,
        output inReady, out, outValid, overflow
    );
endinterface

// File: rtl/redutor.sv
// ----------------------------------------------------------------------------
// redutor
//   Narrowing unit: the inverse of the 16->32 extender. Takes a tamIn-bit
//   word and returns tamOut-bit beats over a valid/ready handshake.
//     keep mode  : one beat holding one side of the word, overflow flags
//                  any information that was discarded.
//     split mode : two beats carrying both halves (only when
//                  tamIn == 2*tamOut, otherwise the split request is ignored).
//
//   Ports
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    redutor_if.slave handshake bundle (see redutor_if.sv)
//
//   Configuration
//     REDUTOR_SAT_EN  when defined, keep mode with extSide=0 saturates the
//                     result on overflow instead of truncating it.
//
//   The interface instance must be built with the same tamIn/tamOut as this
//   module. tamOut < tamIn is required.
// ----------------------------------------------------------------------------
module redutor #(
    parameter int tamIn  = 32,
    parameter int tamOut = 16
) (
    input logic       clk,
    input logic       rst_n,
    redutor_if.slave  bus
);
    localparam int tamN     = tamIn - tamOut;
    localparam bit SPLIT_OK = (tamIn == 2 * tamOut);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t            r_state;
    logic [tamOut-1:0] r_out;
    logic              r_out_valid;
    logic              r_overflow;
    logic [tamOut-1:0] r_second;   // beat 1 of a split word, captured on acceptance
    logic              r_split;    // split mode of the word currently in flight

    logic [tamOut-1:0] w_low;
    logic [tamOut-1:0] w_high;
    logic [tamOut-1:0] w_beat0;
    logic [tamOut-1:0] w_second;
    logic              w_ovf;
    logic              w_ext;
    logic              w_split;
    logic              w_last;
    logic              w_in_ready;
    logic              w_accept;

    assign w_low  = bus.in[tamOut-1:0];
    assign w_high = bus.in[tamIn-1:tamN];

    // Beat 0, overflow and the pending second beat, all computed from the
    // live input so they can be captured on the accepting edge.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_split  = bus.split && SPLIT_OK;
        w_ext    = bus.twoComplement & bus.in[tamOut-1];
        w_beat0  = w_low;
        w_second = w_high;
        w_ovf    = 1'b0;
        if (w_split) begin
            if (bus.extSide) begin
                w_beat0  = w_high;
                w_second = w_low;
            end
        end else if (bus.extSide) begin
            // Keeping the high side: anything set in the dropped low bits is lost.
            w_beat0 = w_high;
            w_ovf   = |bus.in[tamN-1:0];
        end else begin
            // Keeping the low side: the dropped high bits must all equal the
            // extension bit (0 unsigned, sign of the kept part when signed).
            w_ovf = (bus.in[tamIn-1:tamOut] != {tamN{w_ext}});
`ifdef REDUTOR_SAT_EN
            if (w_ovf) begin
                if (!bus.twoComplement)
                    w_beat0 = '1;
                else if (bus.in[tamIn-1])
                    w_beat0 = {1'b1, {(tamOut-1){1'b0}}};
                else
                    w_beat0 = {1'b0, {(tamOut-1){1'b1}}};
            end
`endif
        end
    end

    // The beat on display is the last one of its word.
    assign w_last     = (r_state == BEAT1) || ((r_state == BEAT0) && !r_split);
    assign w_in_ready = (r_state == IDLE) || (r_out_valid && bus.outReady && w_last);
    assign w_accept   = bus.inValid && w_in_ready;

    // Acceptance takes priority: it only happens in IDLE or when the last beat
    // is consumed, so loading the new beat 0 covers the back-to-back case.
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_second    <= '0;
            r_split     <= 1'b0;
        end else if (w_accept) begin
            r_state     <= BEAT0;
            r_out       <= w_beat0;
            r_out_valid <= 1'b1;
            r_overflow  <= w_ovf;
            r_second    <= w_second;
            r_split     <= w_split;
        end else if (bus.outReady) begin
            case (r_state)
                BEAT0: begin
                    if (r_split) begin
                        r_state    <= BEAT1;
                        r_out      <= r_second;
                        r_overflow <= 1'b0;
                    end else begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                BEAT1: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inReady  = w_in_ready;
    assign bus.out      = r_out;
    assign bus.outValid = r_out_valid;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_redutor.sv
// ----------------------------------------------------------------------------
// tb_redutor
//   Directed bench for redutor with default parameters (32 -> 16).
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
//   Expectations that depend on REDUTOR_SAT_EN follow the same macro.
// ----------------------------------------------------------------------------
module tb_redutor;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    redutor_if #(.tamIn(32), .tamOut(16)) bus ();

    redutor #(.tamIn(32), .tamOut(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute bound on the run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w, input logic e, input logic t, input logic s);
        bus.in            = w;
        bus.extSide       = e;
        bus.twoComplement = t;
        bus.split         = s;
        bus.inValid       = 1'b1;
    endtask

    // One keep-mode word with outReady=1: accept, check beat, check drain.
    task automatic keep_one(input string tag, input logic [31:0] w, input logic e, input logic t,
                            input logic [15:0] exp_out, input logic exp_ovf);
        put(w, e, t, 1'b0);
        bus.outReady = 1'b1;
        tick();
        bus.inValid = 1'b0;
        check({tag, ".valid"}, bus.outValid, 1);
        check({tag, ".out"}, bus.out, exp_out);
        check({tag, ".ovf"}, bus.overflow, exp_ovf);
        tick();
        check({tag, ".drain"}, bus.outValid, 0);
    endtask

    logic [31:0] bb [4];
    logic [15:0] exp_u;
    logic [15:0] exp_p;
    logic [15:0] exp_n;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bb      = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404};
`ifdef REDUTOR_SAT_EN
        exp_u = 16'hFFFF;
        exp_p = 16'h7FFF;
        exp_n = 16'h8000;
`else
        exp_u = 16'h8001;
        exp_p = 16'h0000;
        exp_n = 16'h0000;
`endif

        // Reset
        rst_n            = 1'b0;
        bus.in           = '0;
        bus.inValid      = 1'b0;
        bus.extSide      = 1'b0;
        bus.twoComplement = 1'b0;
        bus.split        = 1'b0;
        bus.outReady     = 1'b0;
        tick();
        tick();
        check("rst.valid", bus.outValid, 0);
        check("rst.out", bus.out, 0);
        check("rst.ovf", bus.overflow, 0);
        rst_n = 1'b1;
        tick();
        check("rst.inReady", bus.inReady, 1);

        // Keep mode, low side
        keep_one("keep_u", 32'h0000_1234, 1'b0, 1'b0, 16'h1234, 1'b0);
        keep_one("keep_s_ok", 32'hFFFF_8001, 1'b0, 1'b1, 16'h8001, 1'b0);
        keep_one("keep_u_ovf", 32'hFFFF_8001, 1'b0, 1'b0, exp_u, 1'b1);
        keep_one("keep_s_pos", 32'h0001_0000, 1'b0, 1'b1, exp_p, 1'b1);
        keep_one("keep_s_neg", 32'hFFFE_0000, 1'b0, 1'b1, exp_n, 1'b1);
        // Keep mode, high side: never saturates
        keep_one("keep_hi", 32'h1234_0001, 1'b1, 1'b1, 16'h1234, 1'b1);
        keep_one("keep_hi_ok", 32'h8765_0000, 1'b1, 1'b0, 16'h8765, 1'b0);

        // Split, low half first
        put(32'hABCD_1234, 1'b0, 1'b0, 1'b1);
        bus.outReady = 1'b1;
        tick();
        bus.inValid = 1'b0;
        check("split0.b0", bus.out, 16'h1234);
        check("split0.b0v", bus.outValid, 1);
        check("split0.b0ovf", bus.overflow, 0);
        check("split0.b0rdy", bus.inReady, 0);
        tick();
        check("split0.b1", bus.out, 16'hABCD);
        check("split0.b1v", bus.outValid, 1);
        check("split0.b1rdy", bus.inReady, 1);
        tick();
        check("split0.drain", bus.outValid, 0);

        // Split, high half first
        put(32'hABCD_1234, 1'b1, 1'b0, 1'b1);
        tick();
        bus.inValid = 1'b0;
        check("split1.b0", bus.out, 16'hABCD);
        tick();
        check("split1.b1", bus.out, 16'h1234);
        check("split1.b1ovf", bus.overflow, 0);
        tick();
        check("split1.drain", bus.outValid, 0);

        // Split with beat 0 stalled for 3 cycles; unrelated input must be ignored
        put(32'hABCD_1234, 1'b0, 1'b0, 1'b1);
        bus.outReady = 1'b0;
        tick();
        put(32'h5555_5555, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("hold.out", bus.out, 16'h1234);
            check("hold.valid", bus.outValid, 1);
            check("hold.inReady", bus.inReady, 0);
            tick();
        end
        check("hold.out_end", bus.out, 16'h1234);
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        tick();
        check("hold.b1", bus.out, 16'hABCD);
        tick();
        check("hold.drain", bus.outValid, 0);

        // Four back-to-back keep words
        for (int i = 0; i < 4; i++) begin
            put(bb[i], 1'b0, 1'b0, 1'b0);
            #1;
            check("b2b.inReady", bus.inReady, 1);
            tick();
            check("b2b.out", bus.out, {16'h0, bb[i][15:0]});
            check("b2b.valid", bus.outValid, 1);
            check("b2b.ovf", bus.overflow, 0);
        end
        bus.inValid = 1'b0;
        tick();
        check("b2b.drain", bus.outValid, 0);

        // Reset pulse during beat 0 of a split word
        put(32'hABCD_1234, 1'b0, 1'b0, 1'b1);
        tick();
        bus.inValid = 1'b0;
        check("rstmid.pre", bus.outValid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.valid", bus.outValid, 0);
        check("rstmid.out", bus.out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstmid.nobeat", bus.outValid, 0);
        put(32'h0000_00AA, 1'b0, 1'b0, 1'b1);
        tick();
        bus.inValid = 1'b0;
        check("rstmid.b0", bus.out, 16'h00AA);
        check("rstmid.b0v", bus.outValid, 1);
        tick();
        check("rstmid.b1", bus.out, 16'h0000);
        check("rstmid.b1v", bus.outValid, 1);
        tick();
        check("rstmid.drain", bus.outValid, 0);
        tick();
        check("rstmid.idle", bus.outValid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/redutor.md
# redutor

Narrowing unit, the inverse of the CPU datapath's 16→32 extender: takes a `tamIn`-bit word and returns `tamOut`-bit results through a valid/ready handshake. Two modes:
- **Keep mode:** keeps one side of the word and flags lost information (`overflow`).
- **Split mode:** emits both halves as two beats.

It sits between the 32-bit register/ALU datapath and 16-bit consumers such as halfword stores and immediate write-back.

## Interface
Parameters:
- `tamIn`, 32: input width.
- `tamOut`, 16: output width. Requires `tamOut < tamIn`.
- `tamN`, localparam, `tamIn-tamOut`: discarded width. Not overridable.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in`  in  `tamIn`  input word.
- `inValid`  in  1  input word present.
- `inReady`  out  1  unit accepts a word this cycle.
- `extSide`  in  1  0: keep the low side (undo left extension); 1: keep the high side.
- `twoComplement`  in  1  1: signed overflow check.
- `split`  in  1  1: emit both halves as two beats. Legal only when `tamIn == 2*tamOut`; ignored otherwise.
- `out`  out  `tamOut`  result beat, registered.
- `outValid`  out  1  `out` is valid.
- `outReady`  in  1  consumer takes the beat.
- `overflow`  out  1  information lost in the current beat, registered.

## Operation
- `extSide`, `twoComplement` and `split` are sampled with `in` on acceptance (`inValid && inReady`) and held internally.
- **Keep mode, `extSide=0`:**
  - `out = in[tamOut-1:0]`.
  - `overflow=1` if `in[tamIn-1:tamOut]` is not all copies of the extension bit.
  - The extension bit is 0 when `twoComplement=0`, and `in[tamOut-1]` when `twoComplement=1`.
- **Keep mode, `extSide=1`:**
  - `out = in[tamIn-1:tamN]`.
  - `overflow=1` if `in[tamN-1:0] != 0`. `twoComplement` has no effect.
- **Split mode:**
  - `extSide=0`: beat 0 = low half, beat 1 = high half.
  - `extSide=1`: beat 0 = high half, beat 1 = low half.
  - `overflow=0` on both beats.
- **FSM:**
  - `IDLE` → `BEAT0` on acceptance.
  - `BEAT0` on `outReady`: → `BEAT1` if split; otherwise → `BEAT0` if a new word is accepted in the same cycle, else → `IDLE`.
  - `BEAT1` on `outReady`: → `BEAT0` if a word is accepted in the same cycle, else → `IDLE`.
- **Output hold:** `outValid=1` in `BEAT0` and `BEAT1`. While `outReady=0`, `out` and `overflow` hold stable.
- **`inReady` (combinational):** `(state==IDLE) || (outValid && outReady && lastBeat)`, where `lastBeat` = `BEAT1`, or `BEAT0` in keep mode.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - `state=IDLE`, `out=0`, `outValid=0`, `overflow=0`.
  - `inReady=1` from the first cycle after release.
- Latency: word accepted at edge N → `outValid=1` with beat 0 after edge N, i.e. visible in cycle N+1.
- Throughput with `outReady` held at 1: keep mode, one word per cycle; split mode, one word per two cycles.
- Back-to-back: when the last beat is consumed and a new word is accepted on the same edge, the new beat 0 replaces it with no bubble.
- Reset during `BEAT0`/`BEAT1`: the pending word is dropped, `outValid` falls immediately (asynchronously), and no beat is emitted after release.
- `inValid` may drop or change freely while `inReady=0`; nothing is sampled then.

## Configuration
- `REDUTOR_SAT_EN` **defined:** in keep mode with `extSide=0` and `overflow=1`, `out` saturates:
  - unsigned: all ones;
  - signed with `in[tamIn-1]=0`: `{0, {tamOut-1{1}}}`;
  - signed with `in[tamIn-1]=1`: `{1, {tamOut-1{0}}}`.
- `REDUTOR_SAT_EN` **undefined:** plain truncation in all cases; `overflow` is still reported.
- Neither setting affects `extSide=1` or split mode.

## Test plan
All cases use default parameters.
- Keep, `extSide=0`, `twoComplement=0`, `in=0x0000_1234`:
  - `out=0x1234`, `overflow=0`, `outValid` one cycle after acceptance.
- Keep, `extSide=0`, `in=0xFFFF_8001`:
  - `twoComplement=1`: `out=0x8001`, `overflow=0`.
  - `twoComplement=0`: `overflow=1`; `out=0x8001` without `REDUTOR_SAT_EN`, `0xFFFF` with it.
- `REDUTOR_SAT_EN` defined, `twoComplement=1`:
  - `in=0x0001_0000` → `out=0x7FFF`, `overflow=1`.
  - `in=0xFFFE_0000` → `out=0x8000`, `overflow=1`.
  - `extSide=1`, `in=0x1234_0001` → `out=0x1234`, `overflow=1`, no saturation.
- Split, `in=0xABCD_1234`:
  - `extSide=0`: beats `0x1234` then `0xABCD`.
  - `extSide=1`: beats `0xABCD` then `0x1234`.
  - With `outReady=0` for 3 cycles on beat 0: the beat holds and `inReady=0` throughout.
- Four keep-mode words with `inValid=outReady=1` continuously:
  - four consecutive valid beats, no bubble, `inReady` stays 1.
- `rst_n` pulsed low during `BEAT0` of a split word:
  - `outValid=0` immediately; after release the next word `0x0000_00AA` yields only its own beats.
